// File: rtl/mem_wb_skid_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_skid_reg
//   MEM->WB pipeline register with a valid/ready handshake and a two-entry
//   skid buffer (head + skid). The head entry drives the outputs. The
//   writeback value is selected combinationally from the head fields. A
//   forwarding tap is also exposed for the hazard unit.
//
//   in_ready is derived only from registered state (~skid_valid), so there is
//   no combinational path from out_ready to in_ready. The skid entry catches
//   the one beat that may arrive while the head is stalled.
//
// Ports
//   clk, reset        clock; synchronous active-high reset (overrides flush)
//   flush             synchronous bubble insert, discards both entries
//   in_valid/in_ready upstream handshake
//   in_mem_data, in_calc_data, in_rd, in_reg_we, in_mem_to_reg
//                     entry payload from the MEM stage
//   out_valid/out_ready downstream handshake
//   out_mem_data, out_calc_data, out_rd   head payload
//   out_reg_we        head write enable, gated by out_valid
//   out_wb_data       head_mem_to_reg ? out_mem_data : out_calc_data
//   fwd_valid/fwd_rd/fwd_data  forwarding tap (rd == 0 never forwards)
// ---------------------------------------------------------------------------
module mem_wb_skid_reg #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_mem_data,
    input  logic [DATA_W-1:0]  in_calc_data,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_reg_we,
    input  logic               in_mem_to_reg,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_mem_data,
    output logic [DATA_W-1:0]  out_calc_data,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_reg_we,
    output logic [DATA_W-1:0]  out_wb_data,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]  fwd_data
);

    // Packed entry layout: {mem_data, calc_data, rd, reg_we, mem_to_reg}
    localparam int ENTRY_W = 2 * DATA_W + RADDR_W + 2;

    logic [ENTRY_W-1:0] in_entry_s;
    logic [ENTRY_W-1:0] head_r;
    logic [ENTRY_W-1:0] skid_r;
    logic               head_valid_r;
    logic               skid_valid_r;

    logic [ENTRY_W-1:0] head_nxt_s;
    logic [ENTRY_W-1:0] skid_nxt_s;
    logic               head_valid_nxt_s;
    logic               skid_valid_nxt_s;

    logic               accept_s;
    logic               pop_s;

    logic [DATA_W-1:0]  head_mem_s;
    logic [DATA_W-1:0]  head_calc_s;
    logic [RADDR_W-1:0] head_rd_s;
    logic               head_we_s;
    logic               head_m2r_s;

    assign in_entry_s = {in_mem_data, in_calc_data, in_rd, in_reg_we, in_mem_to_reg};
    assign {head_mem_s, head_calc_s, head_rd_s, head_we_s, head_m2r_s} = head_r;

    // The skid is only ever occupied while the head is occupied, so a free
    // skid slot is sufficient to guarantee room for one more entry.
    assign in_ready = ~skid_valid_r;
    assign accept_s = in_valid & ~skid_valid_r;
    assign pop_s    = head_valid_r & out_ready;

    // Next-state selection for head/skid storage from {head_valid, pop, accept}
    always_comb begin
        head_nxt_s       = head_r;
        skid_nxt_s       = skid_r;
        head_valid_nxt_s = head_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        case ({head_valid_r, pop_s, accept_s})
            3'b001: begin
                // Empty: new entry lands directly in head.
                head_nxt_s       = in_entry_s;
                head_valid_nxt_s = 1'b1;
            end
            3'b101: begin
                // Head stalled: park the new entry in the skid.
                skid_nxt_s       = in_entry_s;
                skid_valid_nxt_s = 1'b1;
            end
            3'b110: begin
                // Pop without accept: promote skid, or go empty.
                if (skid_valid_r) begin
                    head_nxt_s       = skid_r;
                    skid_valid_nxt_s = 1'b0;
                end else begin
                    head_valid_nxt_s = 1'b0;
                end
            end
            3'b111: begin
                // Pop + accept implies skid empty: replace head in place.
                head_nxt_s = in_entry_s;
            end
            default: begin
                head_nxt_s       = head_r;
                skid_nxt_s       = skid_r;
                head_valid_nxt_s = head_valid_r;
                skid_valid_nxt_s = skid_valid_r;
            end
        endcase
    end

    // State register: reset clears everything, flush clears only the valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r       <= {ENTRY_W{1'b0}};
            skid_r       <= {ENTRY_W{1'b0}};
            head_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (flush) begin
            head_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            head_r       <= head_nxt_s;
            skid_r       <= skid_nxt_s;
            head_valid_r <= head_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end

    // Data fields may hold stale values after flush; every control output is
    // gated by head validity so stale data is never acted upon.
    assign out_valid     = head_valid_r;
    assign out_mem_data  = head_mem_s;
    assign out_calc_data = head_calc_s;
    assign out_rd        = head_rd_s;
    assign out_reg_we    = head_we_s & head_valid_r;
    assign out_wb_data   = head_m2r_s ? head_mem_s : head_calc_s;

    assign fwd_valid = head_valid_r & head_we_s & (head_rd_s != {RADDR_W{1'b0}});
    assign fwd_rd    = head_rd_s;
    assign fwd_data  = out_wb_data;

endmodule
